// File: rtl/mem_store_buffer_pkg.sv
// rtl/mem_store_buffer_pkg.sv - shared opcodes and sizing for the DataMem store buffer
package mem_store_buffer_pkg;

    localparam logic [5:0] OP_SDW  = 6'd43;
    localparam logic [5:0] OP_IDLE = 6'd0;

    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = 2;

endpackage

// File: rtl/sb_match_select.sv
// rtl/sb_match_select.sv - youngest-match address compare for store-to-load forwarding
module sb_match_select #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH-1:0][31:0] addr,
    input  logic [DEPTH-1:0][31:0] data,
    input  logic [31:0]            ld_addr,
    input  logic [PTR_W-1:0]       wr_ptr,
    output logic                   hit,
    output logic [31:0]            hit_data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the youngest matching entry overrides the rest.
    always_comb begin
        hit      = 1'b0;
        hit_data = 32'd0;
        idx      = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - PTR_W'(k);
            if (valid[idx] && (addr[idx] == ld_addr)) begin
                hit      = 1'b1;
                hit_data = data[idx];
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - store FIFO and DataMem port arbiter with load forwarding
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        ld_hit,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_data,
    output logic [5:0]  dm_opcode,
    input  logic [31:0] dm_out,
    output logic        empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0][31:0] addr_q;
    logic [DEPTH-1:0][31:0] data_q;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;

    logic                   full;
    logic                   push;
    logic                   drain;
    logic [DEPTH-1:0]       valid;
    logic                   fwd_hit;
    logic [31:0]            fwd_data;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign st_ready = !full;
    assign push     = st_valid && !full;
    // Loads own the shared address port; stores only drain in load-free cycles.
    assign drain    = !empty && !ld_req;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (drain)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, drain};
        end
    end

    // Entry storage needs no reset; validity comes solely from the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
        end
    end

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++)
            valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
    end

    sb_match_select #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .valid    (valid),
        .addr     (addr_q),
        .data     (data_q),
        .ld_addr  (ld_addr),
        .wr_ptr   (wr_ptr),
        .hit      (fwd_hit),
        .hit_data (fwd_data)
    );

    assign ld_hit  = fwd_hit;
    assign ld_data = fwd_hit ? fwd_data : dm_out;

    always_comb begin
        dm_addr   = 32'd0;
        dm_data   = 32'd0;
        dm_opcode = OP_IDLE;
        if (drain) begin
            dm_addr   = addr_q[rd_ptr];
            dm_data   = data_q[rd_ptr];
            dm_opcode = OP_SDW;
        end else if (ld_req) begin
            dm_addr   = ld_addr;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - directed self-checking bench for mem_store_buffer
module tb_mem_store_buffer;

    localparam logic [5:0] SDW = 6'd43;

    logic        CLK;
    logic        RSTn;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic [5:0]  dm_opcode;
    logic [31:0] dm_out;
    logic        empty;

    logic [31:0] mem [64];
    logic        preload;

    int n_cmp;
    int n_bad;

    mem_store_buffer dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_hit    (ld_hit),
        .dm_addr   (dm_addr),
        .dm_data   (dm_data),
        .dm_opcode (dm_opcode),
        .dm_out    (dm_out),
        .empty     (empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DataMem model: combinational read, write on the falling edge.
    assign dm_out = mem[dm_addr[5:0]];

    always @(negedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 64; i++)
                mem[i] = i;
        end else if (dm_opcode == SDW) begin
            mem[dm_addr[5:0]] = dm_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0;
        st_addr  = 32'd0;
        st_data  = 32'd0;
        ld_req   = 1'b0;
        ld_addr  = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        preload = 1'b1;
        RSTn    = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        preload = 1'b0;
        #1;
        chk("reset st_ready", 32'(st_ready), 32'd1);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset dm_opcode", 32'(dm_opcode), 32'd0);
        chk("reset dm_data", dm_data, 32'd0);
        chk("reset dm_addr idle", dm_addr, 32'd0);
        ld_req  = 1'b1;
        ld_addr = 32'd5;
        #1;
        chk("reset load dm_addr", dm_addr, 32'd5);
        chk("reset load data", ld_data, 32'd5);
        chk("reset load hit", 32'(ld_hit), 32'd0);
        idle_inputs();
        @(negedge CLK);
        RSTn = 1'b1;
        step();
    endtask

    task automatic test_single_store();
        st_valid = 1'b1;
        st_addr  = 32'd10;
        st_data  = 32'h0000_AAAA;
        #1;
        chk("push no bypass opcode", 32'(dm_opcode), 32'd0);
        step();
        st_valid = 1'b0;
        #1;
        chk("drain opcode", 32'(dm_opcode), 32'(SDW));
        chk("drain addr", dm_addr, 32'd10);
        chk("drain data", dm_data, 32'h0000_AAAA);
        chk("drain not empty", 32'(empty), 32'd0);
        step();
        chk("single empty after", 32'(empty), 32'd1);
        chk("single mem[10]", mem[10], 32'h0000_AAAA);
    endtask

    task automatic test_load_priority();
        ld_req   = 1'b1;
        ld_addr  = 32'd7;
        st_valid = 1'b1;
        st_addr  = 32'd7;
        st_data  = 32'h11;
        #1;
        chk("prio pre-push hit", 32'(ld_hit), 32'd0);
        chk("prio pre-push data", ld_data, 32'd7);
        step();
        st_data = 32'h22;
        #1;
        chk("prio hit first", 32'(ld_hit), 32'd1);
        chk("prio data first", ld_data, 32'h11);
        chk("prio no drain 1", 32'(dm_opcode), 32'd0);
        step();
        st_valid = 1'b0;
        #1;
        chk("prio youngest hit", 32'(ld_hit), 32'd1);
        chk("prio youngest data", ld_data, 32'h22);
        chk("prio no drain 2", 32'(dm_opcode), 32'd0);
        chk("prio dm_addr load", dm_addr, 32'd7);
        step();
        ld_req = 1'b0;
        #1;
        chk("prio drain1 opcode", 32'(dm_opcode), 32'(SDW));
        chk("prio drain1 data", dm_data, 32'h11);
        step();
        chk("prio drain2 data", dm_data, 32'h22);
        step();
        chk("prio empty", 32'(empty), 32'd1);
        chk("prio mem[7]", mem[7], 32'h22);
    endtask

    task automatic test_full();
        ld_req  = 1'b1;
        ld_addr = 32'd0;
        for (int k = 0; k < 4; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'd20 + 32'(k);
            st_data  = 32'h100 + 32'(k);
            step();
        end
        st_addr = 32'd24;
        st_data = 32'h104;
        #1;
        chk("full st_ready", 32'(st_ready), 32'd0);
        chk("full not empty", 32'(empty), 32'd0);
        ld_addr = 32'd22;
        #1;
        chk("full fwd hit", 32'(ld_hit), 32'd1);
        chk("full fwd data", ld_data, 32'h102);
        step();
        st_valid = 1'b0;
        ld_req   = 1'b0;
        ld_addr  = 32'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full drain opcode", 32'(dm_opcode), 32'(SDW));
            chk("full drain addr", dm_addr, 32'd20 + 32'(k));
            chk("full drain data", dm_data, 32'h100 + 32'(k));
            step();
        end
        chk("full empty after", 32'(empty), 32'd1);
        chk("full dropped mem[24]", mem[24], 32'd24);
        chk("full mem[23]", mem[23], 32'h103);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'd30 + 32'(k);
            st_data  = 32'h200 + 32'(k);
            #1;
            if (k == 0) begin
                chk("b2b first no drain", 32'(dm_opcode), 32'd0);
            end else begin
                chk("b2b drain addr", dm_addr, 32'd30 + 32'(k - 1));
                chk("b2b st_ready", 32'(st_ready), 32'd1);
            end
            step();
        end
        st_valid = 1'b0;
        #1;
        chk("b2b last drain addr", dm_addr, 32'd35);
        step();
        chk("b2b empty", 32'(empty), 32'd1);
        for (int k = 0; k < 6; k++)
            chk("b2b mem", mem[30 + k], 32'h200 + 32'(k));
    endtask

    task automatic test_reset_mid_drain();
        ld_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'd40 + 32'(k);
            st_data  = 32'h300 + 32'(k);
            step();
        end
        st_valid = 1'b0;
        ld_req   = 1'b0;
        #1;
        chk("mid drain opcode", 32'(dm_opcode), 32'(SDW));
        RSTn = 1'b0;
        #1;
        chk("mid reset empty", 32'(empty), 32'd1);
        chk("mid reset st_ready", 32'(st_ready), 32'd1);
        chk("mid reset opcode", 32'(dm_opcode), 32'd0);
        step();
        step();
        RSTn = 1'b1;
        step();
        chk("mid reset still empty", 32'(empty), 32'd1);
        for (int k = 0; k < 3; k++)
            chk("mid reset mem kept", mem[40 + k], 32'd40 + 32'(k));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_store();
        test_load_priority();
        test_full();
        test_back_to_back();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
